rho_rotate_func: RTL
====================

Name: rho_rotate_func

Overview:
- Lane-rotation (rho) stage sitting directly upstream of permutation_func; its output stream is what drives that block's line_in.
- Collects one full 5x5x64 state as 64 consecutive 25-bit slices.
- Rotates each of the 25 lanes along z by the fixed Keccak rho offset, then emits the 64 rotated slices in order.
- Buffers a whole state, because an output slice depends on input slices from across the full depth.

Parameters:
- DEPTH, 64: slices per state. 64 is the only legal value; offsets are taken mod 64.
- CNT_W, 7: width of the slice counter and cnt_value.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- start, input, 1: one-cycle request to begin a load; honoured only in IDLE.
- in_valid, input, 1: line_in holds a valid slice.
- line_in, input, 25: input slice z; bit index 5*y+x is lane (x,y).
- in_ready, output, 1: block accepts a slice this cycle.
- out_valid, output, 1: out_line holds a valid rotated slice.
- out_ready, input, 1: downstream accepts out_line this cycle.
- out_line, output, 25: rotated slice at index cnt_value.
- cnt_value, output, CNT_W: current slice index (load or emit).
- busy, output, 1: high in LOAD, EMIT and DONE.
- done, output, 1: one-cycle pulse after the last slice is accepted.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; counter = 0; all 25 lane registers (64 bits each) are cleared.
  - Outputs in_ready, out_valid, busy and done are 0; cnt_value = 0; out_line = 0.
- States: IDLE, LOAD, EMIT, DONE.
- IDLE:
  - start=1 -> LOAD; counter = 0.
  - in_ready=0, so a slice presented in the same cycle as start is not accepted.
- LOAD:
  - in_ready=1.
  - On in_valid=1: line_in bit (5*y+x) is written to lane[x,y] bit [counter], and counter increments.
  - When the beat at counter=63 is accepted: go to EMIT with counter = 0 (wrap, no co stall).
  - in_valid=0 holds the state and counter.
- EMIT:
  - out_valid=1.
  - out_line bit (5*y+x) = lane[x,y][(counter - R[x,y]) mod 64]. This is combinational from the counter and lane registers; out_line is stable while out_ready=0.
  - On out_ready=1: counter increments.
  - When the beat at counter=63 is accepted: go to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE with counter = 0.
- Outside EMIT, out_line = 0 and out_valid = 0.
- Rho offsets R[x,y], listed in order y=0..4:
  - x=0: 0, 36, 3, 41, 18
  - x=1: 1, 44, 10, 45, 2
  - x=2: 62, 6, 43, 15, 61
  - x=3: 28, 55, 25, 21, 56
  - x=4: 27, 20, 39, 8, 14
- Index arithmetic is 6-bit modular; cnt_value[6] is 0 in all states.
- Ignored inputs:
  - start is ignored in LOAD, EMIT and DONE.
  - in_valid is ignored outside LOAD.
  - out_ready is ignored outside EMIT.
- Lane registers are not cleared between states. A new LOAD overwrites all 64 positions before EMIT reads any of them, so stale data is never visible.
- rst asserted at any point mid-LOAD or mid-EMIT aborts the operation immediately with reset values. No done pulse is produced.
- Throughput: 64 load cycles + 64 emit cycles + 1 DONE cycle, minimum, per state.

Test Plan:
- Reset: assert rst mid-cycle -> in_ready=0, out_valid=0, done=0, busy=0, cnt_value=0 immediately (before the next clk edge).
- Zero-offset lane: load 64 slices with only bit 0 set at z=5 -> in EMIT only slice 5 has out_line=25'h0000001; all other slices are 0; done pulses once after slice 63.
- Wrap rotation: set lane (2,0) (bit 2) at z=3 only -> output bit 2 appears at slice (3+62) mod 64 = 1 only. Lane (1,0) bit at z=63 -> appears at slice 0.
- Backpressure: drop out_ready for 5 cycles at cnt_value=10 -> out_line and cnt_value hold; no slice is skipped; 64 beats total are accepted.
- Gaps on input: deassert in_valid on every other cycle in LOAD -> exactly 64 accepted beats before EMIT; start pulses during LOAD and EMIT are ignored.
- Reset mid-EMIT at cnt_value=30 -> IDLE; a fresh start plus load of all-ones -> every output slice = 25'h1FFFFFF.

Source files
------------

// File: rtl/rho_rotate_func.sv
`default_nettype none
// ============================================================================
//  Module      : rho_rotate_func
//  Description : Keccak rho stage working on a slice stream. A full 5x5x64
//                state is collected as 64 consecutive 25-bit slices. Each lane
//                is rotated along z by its fixed rho offset. The rotated state
//                is then emitted as 64 slices in index order.
//  Revision    : 1.0 - initial release
// ============================================================================
module rho_rotate_func #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [24:0]      line_in,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [24:0]      out_line,
    output logic [CNT_W-1:0] cnt_value,
    output logic             busy,
    output logic             done
);

    // Slice index width; DEPTH is fixed at 64, so indices wrap mod 64 for free.
    localparam int                 c_IDX_W = $clog2(DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(DEPTH - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_EMIT = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    // Rho offset of lane index 5*y+x.
    function automatic int f_rho(input int idx);
        int r;
        case (idx)
            0:  r = 0;   1:  r = 1;   2:  r = 62;  3:  r = 28;  4:  r = 27;
            5:  r = 36;  6:  r = 44;  7:  r = 6;   8:  r = 55;  9:  r = 20;
            10: r = 3;   11: r = 10;  12: r = 43;  13: r = 25;  14: r = 39;
            15: r = 41;  16: r = 45;  17: r = 15;  18: r = 21;  19: r = 8;
            20: r = 18;  21: r = 2;   22: r = 61;  23: r = 56;  24: r = 14;
            default: r = 0;
        endcase
        return r;
    endfunction

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_cnt;
    logic               w_load_beat;
    logic [24:0]        w_rot;

    // A slice is captured only while loading and the source presents one.
    assign w_load_beat = (r_state == c_ST_LOAD) && in_valid;

    // Control FSM: slice counter and state progression IDLE->LOAD->EMIT->DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state <= c_ST_LOAD;
                        r_cnt   <= '0;
                    end
                end
                c_ST_LOAD: begin
                    if (in_valid) begin
                        // Wraps to 0 after slice 63, ready for the first emit beat.
                        r_cnt <= r_cnt + c_IDX_W'(1);
                        if (r_cnt == c_LAST) begin
                            r_state <= c_ST_EMIT;
                        end
                    end
                end
                c_ST_EMIT: begin
                    if (out_ready) begin
                        r_cnt <= r_cnt + c_IDX_W'(1);
                        if (r_cnt == c_LAST) begin
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // One 64-bit lane register per (x,y); read back through the rho offset.
    for (genvar i = 0; i < 25; i++) begin : g_lane
        localparam logic [c_IDX_W-1:0] c_OFF = c_IDX_W'(f_rho(i));

        logic [DEPTH-1:0]   r_lane;
        logic [c_IDX_W-1:0] w_src;

        // Store the incoming bit of this lane at the current slice position.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_lane <= '0;
            end else if (w_load_beat) begin
                r_lane[r_cnt] <= line_in[i];
            end
        end

        // Output slice z takes lane bit (z - offset) mod 64.
        assign w_src    = r_cnt - c_OFF;
        assign w_rot[i] = r_lane[w_src];
    end

    // Status outputs are plain decodes of the state register.
    assign in_ready  = (r_state == c_ST_LOAD);
    assign out_valid = (r_state == c_ST_EMIT);
    assign busy      = (r_state != c_ST_IDLE);
    assign done      = (r_state == c_ST_DONE);
    assign cnt_value = CNT_W'(r_cnt);
    assign out_line  = out_valid ? w_rot : 25'd0;

endmodule
`default_nettype wire
